// File: rtl/fifo_ctrl.sv
// First-word-fall-through FIFO controller that sequences an external dual-port RAM.
// Optional almost_full/almost_empty flags are compiled in with FIFO_CTRL_ALMOST_EN.
module fifo_ctrl #(
  parameter int DATA     = 16,
  parameter int ADDR     = 5,
  parameter int AF_LEVEL = 2**ADDR - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic            clK,
  input  logic            rst_N,
  input  logic            wr_VALID,
  output logic            wr_READY,
  input  logic [DATA-1:0] wr_DATA,
  output logic            rd_VALID,
  input  logic            rd_READY,
  output logic [DATA-1:0] rd_DATA,
  output logic [ADDR+1:0] count,
  output logic            a_port_WR,
  output logic [ADDR-1:0] a_port_ADDR,
  output logic [DATA-1:0] a_port_data_IN,
  output logic            b_port_WR,
  output logic [ADDR-1:0] b_port_ADDR,
  output logic [DATA-1:0] b_port_data_IN,
  input  logic [DATA-1:0] b_port_data_OUT
`ifdef FIFO_CTRL_ALMOST_EN
  ,
  output logic            almost_full,
  output logic            almost_empty
`endif
);

  localparam logic [ADDR:0] DEPTH = {1'b1, {ADDR{1'b0}}};

  logic [ADDR:0]   wr_ptr, rd_ptr, mem_cnt;
  logic            pend, push, pop, issue, full;
  logic [1:0]      occ, occ_next, occ_after_pop;
  logic [2:0]      fill_next;
  logic [DATA-1:0] buf0, buf1, buf0_next, buf1_next;

  assign mem_cnt  = wr_ptr - rd_ptr;
  assign full     = (mem_cnt == DEPTH);
  assign wr_READY = !full;
  assign push     = wr_VALID && wr_READY;

  assign rd_VALID = (occ != 2'd0);
  assign rd_DATA  = buf0;
  assign pop      = rd_VALID && rd_READY;

  // Only issue a read when the output buffer is guaranteed a free slot for its data
  assign fill_next     = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
  assign occ_next      = fill_next[1:0];
  assign occ_after_pop = occ - {1'b0, pop};
  assign issue         = (mem_cnt != '0) && (fill_next <= 3'd1);

  assign count = {1'b0, mem_cnt} + {{(ADDR+1){1'b0}}, pend} + {{ADDR{1'b0}}, occ};

  assign a_port_WR      = push && rst_N;
  assign a_port_ADDR    = wr_ptr[ADDR-1:0];
  assign a_port_data_IN = wr_DATA;
  assign b_port_WR      = 1'b0;
  assign b_port_ADDR    = rd_ptr[ADDR-1:0];
  assign b_port_data_IN = '0;

  always_comb begin
    buf0_next = buf0;
    buf1_next = buf1;
    if (pop)
      buf0_next = buf1;
    if (pend) begin
      if (occ_after_pop == 2'd0)
        buf0_next = b_port_data_OUT;
      else
        buf1_next = b_port_data_OUT;
    end
  end

  always_ff @(posedge clK or negedge rst_N) begin
    if (!rst_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      pend   <= 1'b0;
      occ    <= 2'd0;
      buf0   <= '0;
      buf1   <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (issue)
        rd_ptr <= rd_ptr + 1'b1;
      pend <= issue;
      occ  <= occ_next;
      buf0 <= buf0_next;
      buf1 <= buf1_next;
    end
  end

`ifdef FIFO_CTRL_ALMOST_EN
  logic [ADDR:0]   mem_cnt_next;
  logic [ADDR+1:0] count_next;

  assign mem_cnt_next = mem_cnt + {{ADDR{1'b0}}, push} - {{ADDR{1'b0}}, issue};
  assign count_next   = {1'b0, mem_cnt_next} + {{(ADDR+1){1'b0}}, issue}
                      + {{ADDR{1'b0}}, occ_next};

  always_ff @(posedge clK or negedge rst_N) begin
    if (!rst_N) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (count_next >= (ADDR+2)'(AF_LEVEL));
      almost_empty <= (count_next <= (ADDR+2)'(AE_LEVEL));
    end
  end
`else
  // Flags compiled out; still reject nonsensical threshold overrides at elaboration
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
    $error("fifo_ctrl: AE_LEVEL must be below AF_LEVEL");
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl with a behavioural registered-read dpram.
// Define FIFO_CTRL_ALMOST_EN to also exercise the almost_full/almost_empty flags.
module tb_fifo_ctrl;

  localparam int DATA = 16;
  localparam int ADDR = 3;

  logic            clK = 1'b0;
  logic            rst_N = 1'b0;
  logic            wr_VALID = 1'b0;
  logic [DATA-1:0] wr_DATA = '0;
  logic            rd_READY = 1'b0;
  logic            wr_READY, rd_VALID;
  logic [DATA-1:0] rd_DATA;
  logic [ADDR+1:0] count;
  logic            a_port_WR, b_port_WR;
  logic [ADDR-1:0] a_port_ADDR, b_port_ADDR;
  logic [DATA-1:0] a_port_data_IN, b_port_data_IN;
  logic [DATA-1:0] b_port_data_OUT = '0;
`ifdef FIFO_CTRL_ALMOST_EN
  logic            almost_full, almost_empty;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [DATA-1:0] ram [2**ADDR];
  logic [DATA-1:0] sb [$];

  always #5 clK = ~clK;

  fifo_ctrl #(.DATA(DATA), .ADDR(ADDR), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clK(clK),
    .rst_N(rst_N),
    .wr_VALID(wr_VALID),
    .wr_READY(wr_READY),
    .wr_DATA(wr_DATA),
    .rd_VALID(rd_VALID),
    .rd_READY(rd_READY),
    .rd_DATA(rd_DATA),
    .count(count),
    .a_port_WR(a_port_WR),
    .a_port_ADDR(a_port_ADDR),
    .a_port_data_IN(a_port_data_IN),
    .b_port_WR(b_port_WR),
    .b_port_ADDR(b_port_ADDR),
    .b_port_data_IN(b_port_data_IN),
    .b_port_data_OUT(b_port_data_OUT)
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    .almost_full(almost_full),
    .almost_empty(almost_empty)
`endif
  );

  // Behavioural dpram: port A writes, port B reads with one registered cycle of latency
  always_ff @(posedge clK) begin
    if (a_port_WR)
      ram[a_port_ADDR] <= a_port_data_IN;
    b_port_data_OUT <= ram[b_port_ADDR];
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic wv, input logic [DATA-1:0] wd, input logic rr);
    wr_VALID = wv;
    wr_DATA  = wd;
    rd_READY = rr;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clK);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic            wv, rr;
    logic [DATA-1:0] wd;
    int              pushed, popped, cycles;

    // Reset state, with a push request held to confirm the RAM write is gated
    apply_stimulus(1'b1, 16'hFFFF, 1'b1);
    check_output("rst_rd_valid", rd_VALID, 0);
    check_output("rst_rd_data", rd_DATA, 0);
    check_output("rst_count", count, 0);
    check_output("rst_wr_ready", wr_READY, 1);
    check_output("rst_a_wr", a_port_WR, 0);
    check_output("rst_b_wr", b_port_WR, 0);
    check_output("rst_b_din", b_port_data_IN, 0);
`ifdef FIFO_CTRL_ALMOST_EN
    check_output("rst_almost_full", almost_full, 0);
    check_output("rst_almost_empty", almost_empty, 1);
`endif
    repeat (2) next_cycle();
    apply_stimulus(1'b0, '0, 1'b1);
    rst_N = 1'b1;
    next_cycle();

    // Single word: visible three edges after acceptance, gone after the pop
    apply_stimulus(1'b1, 16'hA5A5, 1'b1);
    check_output("t1_a_wr", a_port_WR, 1);
    check_output("t1_a_addr", a_port_ADDR, 0);
    check_output("t1_a_din", a_port_data_IN, 16'hA5A5);
    next_cycle();
    apply_stimulus(1'b0, '0, 1'b1);
    check_output("t1_e0_valid", rd_VALID, 0);
    check_output("t1_e0_count", count, 1);
    next_cycle();
    check_output("t1_e1_valid", rd_VALID, 0);
    check_output("t1_e1_count", count, 1);
    next_cycle();
    check_output("t1_e2_valid", rd_VALID, 1);
    check_output("t1_e2_data", rd_DATA, 16'hA5A5);
    check_output("t1_e2_count", count, 1);
    next_cycle();
    check_output("t1_e3_valid", rd_VALID, 0);
    check_output("t1_e3_count", count, 0);

    // Fill with no pops: 8 RAM words plus 2 buffered words
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, 16'(i), 1'b0);
      check_output("t2_ready_before_push", wr_READY, 1);
      next_cycle();
      check_output("t2_count", count, i + 1);
`ifdef FIFO_CTRL_ALMOST_EN
      check_output("t2_almost_full", almost_full, (i + 1 >= 6) ? 1 : 0);
      check_output("t2_almost_empty", almost_empty, (i + 1 <= 2) ? 1 : 0);
`endif
    end
    check_output("t2_full_ready", wr_READY, 0);
    check_output("t2_full_count", count, 10);
    check_output("t2_full_valid", rd_VALID, 1);
    check_output("t2_full_head", rd_DATA, 0);
    apply_stimulus(1'b1, 16'd10, 1'b0);
    check_output("t2_push_on_full_wr", a_port_WR, 0);
    next_cycle();
    check_output("t2_hold_count", count, 10);
    check_output("t2_hold_ready", wr_READY, 0);

    // Push and pop together while full: push refused, slot freed next cycle
    apply_stimulus(1'b1, 16'd10, 1'b1);
    check_output("t2_fullpop_wr", a_port_WR, 0);
    check_output("t2_fullpop_head", rd_DATA, 0);
    next_cycle();
    check_output("t2_after_pop_ready", wr_READY, 1);
    check_output("t2_after_pop_count", count, 9);
    for (int i = 1; i <= 10; i++) begin
      apply_stimulus(i == 1, 16'd10, 1'b1);
      check_output("t2_drain_valid", rd_VALID, 1);
      check_output("t2_drain_data", rd_DATA, i);
      next_cycle();
    end
    check_output("t2_empty_count", count, 0);
    check_output("t2_empty_valid", rd_VALID, 0);

    // Streaming: one word in and one word out per cycle across several pointer wraps
    for (int k = 0; k < 42; k++) begin
      apply_stimulus(k < 40, 16'(16'h0100 + k), 1'b1);
      next_cycle();
      if (k >= 2) begin
        check_output("t3_valid", rd_VALID, 1);
        check_output("t3_data", rd_DATA, 16'h0100 + k - 2);
      end
    end
    apply_stimulus(1'b0, '0, 1'b1);
    next_cycle();
    check_output("t3_end_count", count, 0);
    check_output("t3_end_valid", rd_VALID, 0);

    // Consumer stalls every other cycle: head must hold and order must survive
    sb.delete();
    pushed = 0;
    popped = 0;
    cycles = 0;
    rr = 1'b0;
    while (popped < 100 && cycles < 2000) begin
      rr = ~rr;
      wv = (pushed < 100);
      wd = 16'($urandom);
      apply_stimulus(wv, wd, rr);
      if (wv && wr_READY) begin
        sb.push_back(wd);
        pushed++;
      end
      if (rd_VALID) begin
        check_output("t4_no_underflow", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          check_output("t4_data", rd_DATA, sb[0]);
          if (rr) begin
            void'(sb.pop_front());
            popped++;
          end
        end
      end
      next_cycle();
      cycles++;
    end
    check_output("t4_popped", popped, 100);
    check_output("t4_end_count", count, 0);
    check_output("t4_end_valid", rd_VALID, 0);

    // Asynchronous reset mid-stream discards contents
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, 16'(16'h0050 + i), 1'b0);
      next_cycle();
    end
    check_output("t5_count_before", count, 6);
    check_output("t5_valid_before", rd_VALID, 1);
    apply_stimulus(1'b0, '0, 1'b0);
    rst_N = 1'b0;
    #1;
    check_output("t5_rst_valid", rd_VALID, 0);
    check_output("t5_rst_count", count, 0);
    check_output("t5_rst_ready", wr_READY, 1);
`ifdef FIFO_CTRL_ALMOST_EN
    check_output("t5_rst_almost_full", almost_full, 0);
    check_output("t5_rst_almost_empty", almost_empty, 1);
`endif
    next_cycle();
    rst_N = 1'b1;
    next_cycle();
    apply_stimulus(1'b1, 16'h1234, 1'b1);
    next_cycle();
    apply_stimulus(1'b0, '0, 1'b1);
    next_cycle();
    next_cycle();
    check_output("t5_first_valid", rd_VALID, 1);
    check_output("t5_first_data", rd_DATA, 16'h1234);
    next_cycle();
    check_output("t5_end_count", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Synchronous FIFO controller that sequences one dpram instance as a first-word-fall-through queue.
- dpram port A is the write port, driven from a valid/ready push interface.
- dpram port B is the read port, feeding a 2-entry output buffer that presents a valid/ready pop interface.
- Generates pointers, occupancy, full/empty, and absorbs dpram's 1-cycle registered read latency at full throughput.

Parameters:
DATA, 16, word width; must match the dpram DATA.
ADDR, 5, dpram address width; RAM depth is 2**ADDR.
AF_LEVEL, 2**ADDR-2, almost-full threshold on count (optional feature only).
AE_LEVEL, 2, almost-empty threshold on count (optional feature only).

Ports:
clK  input  1  clock, rising edge.
rst_N  input  1  asynchronous active-low reset.
wr_VALID  input  1  push request.
wr_READY  output  1  push accepted when wr_VALID & wr_READY.
wr_DATA  input  DATA  push data.
rd_VALID  output  1  rd_DATA holds the head word.
rd_READY  input  1  pop when rd_VALID & rd_READY.
rd_DATA  output  DATA  head word.
count  output  ADDR+2  total words held (RAM + in flight + output buffer).
a_port_WR  output  1  dpram port A write enable.
a_port_ADDR  output  ADDR  dpram port A address.
a_port_data_IN  output  DATA  dpram port A write data.
b_port_WR  output  1  tied 0.
b_port_ADDR  output  ADDR  dpram port B read address.
b_port_data_IN  output  DATA  tied 0.
b_port_data_OUT  input  DATA  dpram port B registered read data.

Behaviour:
Reset and clocking:
- One clock domain. rst_N asserted asynchronously clears all state.
- Reset values: wr_ptr=0, rd_ptr=0, pend=0, occ=0.
- Output values during reset: rd_VALID=0, rd_DATA=0, count=0, wr_READY=1, a_port_WR=0 (gated by rst_N).
- Reset mid-operation discards all contents; no RAM clearing.

Pointers and flags:
- wr_ptr and rd_ptr are ADDR+1 bits; the MSB is the wrap bit.
- mem_cnt = wr_ptr - rd_ptr, computed modulo 2**(ADDR+1).
- full = (mem_cnt == 2**ADDR). wr_READY = !full, combinational.

Push:
- push = wr_VALID & wr_READY.
- a_port_WR = push; a_port_ADDR = wr_ptr[ADDR-1:0]; a_port_data_IN = wr_DATA.
- wr_ptr increments on push; wraps naturally through the MSB.

Read issue:
- pop = rd_VALID & rd_READY.
- occ (0..2) = output buffer entries. pend = read issued last cycle, data present on b_port_data_OUT this cycle.
- issue = (mem_cnt != 0) & (occ + pend - pop <= 1).
- b_port_ADDR = rd_ptr[ADDR-1:0]. rd_ptr increments on issue. pend_next = issue.
- A word becomes readable only after its write edge, because mem_cnt is registered. A same-address read/write hazard therefore cannot occur.

Output buffer:
- 2-entry FIFO, head = rd_DATA.
- When pend, b_port_data_OUT is appended. Simultaneous pop removes the head. occ_next = occ + pend - pop, which never exceeds 2.
- rd_VALID = (occ != 0). rd_DATA holds its value while rd_VALID & !rd_READY.
- count = mem_cnt + pend + occ; maximum 2**ADDR + 2.

Latency and throughput:
- Write accepted at edge E0: issue in cycle after E0, pend after E1, rd_VALID after E2 (3 cycles).
- Sustained throughput is 1 push and 1 pop per cycle.
- Simultaneous push on full and pop: push is refused that cycle; wr_READY rises the cycle after the issue frees a slot.
- Pop when empty is ignored. Push when full is ignored; wr_DATA is dropped and the producer must hold it.

Optional Feature:
FIFO_CTRL_ALMOST_EN:
- Defined: adds outputs almost_full (1) and almost_empty (1), registered from count_next.
  - almost_full = (count_next >= AF_LEVEL).
  - almost_empty = (count_next <= AE_LEVEL).
  - Reset values: almost_full=0, almost_empty=1.
- Undefined: ports and logic absent; AF_LEVEL/AE_LEVEL unused.

Test Plan:
- ADDR=3, reset, single push of 0xA5A5, rd_READY=1 -> rd_VALID rises 3 cycles after acceptance with rd_DATA=0xA5A5; count returns to 0 after the pop.
- ADDR=3, continuous push 0..11, rd_READY=0 -> 10 words accepted, wr_READY=0 after the 10th, count=10; popping then yields 0..9 in order.
- ADDR=3, continuous push and pop of 40 words -> after 3-cycle fill, one word popped per cycle; data is an exact sequence across 5 pointer wraps.
- rd_READY toggled every cycle with rd_VALID held high -> rd_DATA stable while stalled; no loss or duplication over 100 random words.
- Assert rst_N low mid-stream with count=6 -> rd_VALID=0, count=0, wr_READY=1 immediately; next push 0x1234 emerges first.
- FIFO_CTRL_ALMOST_EN, ADDR=3, AF_LEVEL=6, AE_LEVEL=2 -> almost_full=1 from count 6 upward; almost_empty=1 at count<=2.
